audio_playback_scheduler: RTL and testbench
===========================================

AUDIO_PLAYBACK_SCHEDULER -- requirements
Module: audio_playback_scheduler

Interface
REQ-001 Parameter NUM_SRC, default 4: number of playback requesters, range 2..8.
REQ-002 Parameter DATA_W, default 64: frame width; {right[63:32], left[31:0]}.
REQ-003 ac_bclk  in  1  sole clock, the I2S serial clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sched_en  in  1  global enable; 0 forces IDLE.
REQ-006 src_en  in  NUM_SRC  per-requester enable mask.
REQ-007 s_axis_tvalid  in  NUM_SRC  requester frame valid, one bit per requester.
REQ-008 s_axis_tready  out  NUM_SRC  requester grant/accept, one-hot or zero.
REQ-009 s_axis_tdata  in  NUM_SRC*DATA_W  requester frames; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-010 m_axis_tvalid  out  1  frame buffer full, toward serializer.
REQ-011 m_axis_tready  in  1  serializer frame-fetch pulse (one cycle per LRC frame).
REQ-012 m_axis_tdata  out  DATA_W  frame buffer contents.
REQ-013 grant_id  out  3  index of requester whose frame is in the buffer.
REQ-014 frame_cnt  out  16  frames consumed by serializer.
REQ-015 underrun_cnt  out  16  fetch pulses seen with buffer empty.
REQ-016 cnt_clr  in  1  synchronous clear of frame_cnt and underrun_cnt.

Function
REQ-017 FSM states SHALL be IDLE, ARB, HOLD; encoding is free.
REQ-018 IDLE: when sched_en=1, go to ARB next cycle; else stay.
REQ-019 ARB: req[i] = src_en[i] & s_axis_tvalid[i]; with no req, stay in ARB with s_axis_tready all zero.
REQ-020 ARB with any req: select the first requesting index strictly after last_grant, wrapping modulo NUM_SRC; assert s_axis_tready for that index only, combinationally, in the same cycle.
REQ-021 On that ARB cycle edge: capture the selected s_axis_tdata into the buffer, set grant_id and last_grant to the index, and go to HOLD.
REQ-022 Latency: m_axis_tvalid SHALL rise exactly 1 cycle after the requester handshake.
REQ-023 HOLD: m_axis_tvalid=1 and the buffer is stable; s_axis_tready is all zero.
REQ-024 HOLD with m_axis_tready=1: the frame is consumed, frame_cnt increments, and the state goes to ARB; m_axis_tvalid=0 the next cycle.
REQ-025 The buffer SHALL be released only on m_axis_tready; a frame is never dropped or duplicated.
REQ-026 m_axis_tready=1 while m_axis_tvalid=0 (any state): underrun_cnt increments and the FSM is unaffected.
REQ-027 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-028 cnt_clr=1 clears both counters and has priority over a same-cycle increment.
REQ-029 sched_en=0 in any state: go to IDLE next cycle, clear m_axis_tvalid, keep last_grant; a frame held in the buffer is discarded.
REQ-030 src_en[i] dropping while requester i's frame is held SHALL NOT cancel that frame.
REQ-031 m_axis_tdata SHALL read 0 whenever m_axis_tvalid=0.

Reset
REQ-032 rst_n=0 immediately forces: state IDLE, buffer 0, m_axis_tvalid 0, s_axis_tready 0, grant_id 0, last_grant NUM_SRC-1 (first grant goes to requester 0), and both counters 0.
REQ-033 Reset asserted mid-HOLD SHALL discard the frame; after release, operation restarts from IDLE.

Verification
REQ-034 Requesters 0..3 all valid, fetch every 64 cycles -> grants 0,1,2,3,0; frame_cnt=5; underrun_cnt=0.
REQ-035 Only requester 2 valid, with data 64'hAAAA_5555_1234_5678 -> m_axis_tdata equals that value 1 cycle after the handshake; grant_id=2.
REQ-036 No requester valid, 3 fetch pulses -> underrun_cnt=3; frame_cnt=0; m_axis_tvalid stays 0.
REQ-037 src_en=4'b1010, all valid -> grants alternate 1,3,1,3; requesters 0 and 2 never see s_axis_tready.
REQ-038 Drop sched_en during HOLD, then re-enable with all valid -> m_axis_tvalid falls next cycle; the next grant follows last_grant.
REQ-039 underrun_cnt preloaded to 16'hFFFF, one more underrun -> counter holds 16'hFFFF; cnt_clr on the same cycle as a fetch pulse -> 0.

Source files
------------

// File: rtl/audio_playback_scheduler.sv
// rtl/audio_playback_scheduler.sv - round-robin scheduler feeding one frame buffer toward an I2S serializer.
module audio_playback_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64
) (
  input  logic                      ac_bclk,
  input  logic                      rst_n,
  input  logic                      sched_en,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [2:0]                grant_id,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               underrun_cnt,
  input  logic                      cnt_clr
);

  typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_buf;
  logic                r_tvalid;
  logic [2:0]          r_grant_id;
  logic [2:0]          r_last_grant;
  logic [15:0]         r_frame_cnt;
  logic [15:0]         r_underrun_cnt;

  logic [NUM_SRC-1:0]  w_req;
  logic [NUM_SRC-1:0]  w_rot;
  logic [2:0]          w_shift;
  logic [2:0]          w_off;
  logic [3:0]          w_sum;
  logic [2:0]          w_sel_idx;
  logic                w_sel_valid;
  logic                w_grant;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_consume;
  logic                w_underrun;

  assign w_req   = src_en & s_axis_tvalid;
  // Rotate so bit 0 is the requester right after last_grant; a shift of NUM_SRC is a full wrap.
  assign w_shift = r_last_grant + 3'd1;
  assign w_rot   = NUM_SRC'({w_req, w_req} >> w_shift);

  always_comb begin
    w_off = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
    w_sel_valid = |w_rot;
    w_sum       = {1'b0, w_shift} + {1'b0, w_off};
    w_sel_idx   = (w_sum >= 4'(NUM_SRC)) ? 3'(w_sum - 4'(NUM_SRC)) : 3'(w_sum);
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_sel_idx == 3'(i)) w_sel_data = s_axis_tdata[i*DATA_W +: DATA_W];
    end
  end

  assign w_grant       = (r_state == ARB) && sched_en && w_sel_valid;
  assign s_axis_tready = w_grant ? (NUM_SRC'(1) << w_sel_idx) : '0;
  assign w_consume     = r_tvalid & m_axis_tready;
  assign w_underrun    = ~r_tvalid & m_axis_tready;

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tvalid ? r_buf : '0;
  assign grant_id      = r_grant_id;
  assign frame_cnt     = r_frame_cnt;
  assign underrun_cnt  = r_underrun_cnt;

  always_ff @(posedge ac_bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_buf          <= '0;
      r_tvalid       <= 1'b0;
      r_grant_id     <= '0;
      r_last_grant   <= 3'(NUM_SRC - 1);
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (cnt_clr) begin
        r_frame_cnt    <= '0;
        r_underrun_cnt <= '0;
      end else begin
        if (w_consume && r_frame_cnt != 16'hFFFF)     r_frame_cnt    <= r_frame_cnt + 16'd1;
        if (w_underrun && r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end

      if (!sched_en) begin
        r_state  <= IDLE;
        r_tvalid <= 1'b0;
        r_buf    <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= ARB;
          ARB: begin
            if (w_sel_valid) begin
              r_buf        <= w_sel_data;
              r_grant_id   <= w_sel_idx;
              r_last_grant <= w_sel_idx;
              r_tvalid     <= 1'b1;
              r_state      <= HOLD;
            end
          end
          HOLD: begin
            if (m_axis_tready) begin
              r_tvalid <= 1'b0;
              r_buf    <= '0;
              r_state  <= ARB;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_playback_scheduler.sv
// tb/tb_audio_playback_scheduler.sv - randomized bench with a frame-level reference model.
module tb_audio_playback_scheduler;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sched_en = 1'b0;
  logic [N-1:0]    src_en = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic [DW-1:0]   m_tdata;
  logic [2:0]      grant_id;
  logic [15:0]     frame_cnt;
  logic [15:0]     underrun_cnt;
  logic            cnt_clr = 1'b0;

  audio_playback_scheduler #(.NUM_SRC(N), .DATA_W(DW)) dut (
    .ac_bclk(clk), .rst_n(rst_n), .sched_en(sched_en), .src_en(src_en),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .grant_id(grant_id), .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "active" = scheduler running, "full" = a frame is waiting for the serializer.
  bit          md_active, md_full;
  logic [63:0] md_buf;
  int          md_gid, md_last;
  int          md_fc, md_uc;
  int          grants[$];
  logic [N-1:0] seen_tready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md_active = 0; md_full = 0; md_buf = '0;
    md_gid = 0; md_last = N - 1; md_fc = 0; md_uc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tready", {60'd0, s_tready}, 64'd0);
    chk("rst_gid", {61'd0, grant_id}, 64'd0);
    chk("rst_fcnt", {48'd0, frame_cnt}, 64'd0);
    chk("rst_ucnt", {48'd0, underrun_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Inputs are already applied; check outputs mid-cycle, advance the model, return at next negedge.
  task automatic step();
    logic [N-1:0] et;
    int eidx;
    et = '0;
    eidx = -1;
    #1;
    if (md_active && !md_full && sched_en) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (md_last + k) % N;
        if (eidx < 0 && src_en[j] && s_tvalid[j]) eidx = j;
      end
    end
    if (eidx >= 0) et[eidx] = 1'b1;
    chk("s_tready", {60'd0, s_tready}, {60'd0, et});
    chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, md_full});
    chk("m_tdata", m_tdata, md_full ? md_buf : 64'd0);
    chk("grant_id", {61'd0, grant_id}, 64'(md_gid));
    chk("frame_cnt", {48'd0, frame_cnt}, 64'(md_fc));
    chk("underrun_cnt", {48'd0, underrun_cnt}, 64'(md_uc));
    seen_tready |= s_tready;
    if (eidx >= 0) grants.push_back(eidx);

    if (cnt_clr) begin
      md_fc = 0; md_uc = 0;
    end else begin
      if (m_tready && !md_full && md_uc != 16'hFFFF) md_uc++;
      if (m_tready && md_full && md_fc != 16'hFFFF) md_fc++;
    end
    if (!sched_en) begin
      md_active = 0; md_full = 0;
    end else if (!md_active) begin
      md_active = 1;
    end else if (md_full) begin
      if (m_tready) md_full = 0;
    end else if (eidx >= 0) begin
      md_full = 1; md_buf = s_tdata[eidx*DW +: DW]; md_gid = eidx; md_last = eidx;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = {$urandom, $urandom};
  endtask

  initial begin
    int exp1[5];
    int gidx;
    exp1 = '{0, 1, 2, 3, 0};
    @(negedge clk);
    do_reset();

    // All four requesters, fetch every 64 cycles.
    sched_en = 1; src_en = 4'hF; s_tvalid = 4'hF; rand_data();
    grants.delete();
    for (int c = 0; c < 320; c++) begin
      m_tready = (c % 64 == 63);
      if (c % 64 == 0) rand_data();
      step();
    end
    m_tready = 0;
    chk("t1_ngrants", 64'(grants.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) chk("t1_grant", 64'(grants[i]), 64'(exp1[i]));
    chk("t1_fcnt", {48'd0, frame_cnt}, 64'd5);
    chk("t1_ucnt", {48'd0, underrun_cnt}, 64'd0);

    // Single requester 2 with fixed data.
    do_reset();
    s_tvalid = 4'b0100; s_tdata = '0;
    s_tdata[2*DW +: DW] = 64'hAAAA_5555_1234_5678;
    gidx = -1;
    for (int c = 0; c < 10 && gidx < 0; c++) begin
      if (s_tready[2]) gidx = c;
      step();
    end
    chk("t2_handshake", 64'(gidx >= 0), 64'd1);
    #1;
    chk("t2_tdata", m_tdata, 64'hAAAA_5555_1234_5678);
    chk("t2_gid", {61'd0, grant_id}, 64'd2);
    @(negedge clk);

    // No requester valid: three fetch pulses are underruns.
    do_reset();
    s_tvalid = '0;
    for (int c = 0; c < 12; c++) begin
      m_tready = (c % 4 == 1);
      step();
    end
    m_tready = 0;
    chk("t3_ucnt", {48'd0, underrun_cnt}, 64'd3);
    chk("t3_fcnt", {48'd0, frame_cnt}, 64'd0);

    // Mask 1010: grants alternate 1,3.
    do_reset();
    src_en = 4'b1010; s_tvalid = 4'hF; grants.delete(); seen_tready = '0;
    for (int c = 0; c < 40; c++) begin
      m_tready = (c % 4 == 3);
      rand_data();
      step();
    end
    m_tready = 0;
    chk("t4_ngrants", 64'(grants.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) chk("t4_grant", 64'(grants[i]), (i % 2 == 0) ? 64'd1 : 64'd3);
    chk("t4_never02", {60'd0, seen_tready & 4'b0101}, 64'd0);

    // Drop sched_en while holding, then resume: next grant follows last_grant.
    do_reset();
    src_en = 4'hF; s_tvalid = 4'hF; rand_data();
    for (int c = 0; c < 4; c++) step();
    sched_en = 0; step();
    chk("t5_tvalid_fall", {63'd0, m_tvalid}, 64'd0);
    sched_en = 1; grants.delete();
    for (int c = 0; c < 4; c++) step();
    chk("t5_next_grant", (grants.size() > 0) ? 64'(grants[0]) : 64'hDEAD, 64'd1);

    // Underrun counter saturation, then clear racing a fetch pulse.
    do_reset();
    sched_en = 0; m_tready = 1;
    for (int c = 0; c < 65536; c++) step();
    chk("t6_sat", {48'd0, underrun_cnt}, 64'hFFFF);
    cnt_clr = 1; step();
    cnt_clr = 0; m_tready = 0;
    chk("t6_clr", {48'd0, underrun_cnt}, 64'd0);

    // Random traffic with occasional enable drops, clears and asynchronous resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sched_en = ($urandom_range(0, 7) != 0);
      src_en   = 4'($urandom);
      s_tvalid = 4'($urandom);
      m_tready = ($urandom_range(0, 3) == 0);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      rand_data();
      if ($urandom_range(0, 255) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
